// File: rtl/aqp_ebus_pkg.sv
// ==== aqp_ebus_pkg: shared states, bus bundle and widths for the Z80 ebus arbiter ====
// ==== rev 1.0 ====
`default_nettype none

package aqp_ebus_pkg;

   localparam int unsigned EBUS_A_W = 16;
   localparam int unsigned EBUS_D_W = 8;
   localparam int unsigned HOLD_W   = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_OWN0    = 3'd2,
      ST_OWN1    = 3'd3,
      ST_HANDOFF = 3'd4,
      ST_REL     = 3'd5
   } arb_state_e;

   typedef struct packed {
      logic [EBUS_A_W-1:0] a;
      logic [EBUS_D_W-1:0] wrdata;
      logic                wrdata_en;
      logic                rd_n;
      logic                wr_n;
      logic                mreq_n;
      logic                iorq_n;
   } ebus_bundle_t;

   // Bus value driven whenever nobody holds a grant.
   localparam ebus_bundle_t EBUS_IDLE = {{EBUS_A_W{1'b0}}, {EBUS_D_W{1'b0}}, 1'b0, 4'b1111};

   function automatic logic is_quiet(input ebus_bundle_t b);
      return b.rd_n & b.wr_n & b.mreq_n & b.iorq_n & ~b.wrdata_en;
   endfunction

endpackage

`default_nettype wire

// File: rtl/aqp_sync2.sv
// ==== aqp_sync2: two-flop synchronizer with configurable reset level ====
// ==== rev 1.0 ====
`default_nettype none

module aqp_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

`default_nettype wire

// File: rtl/aqp_ebus_arbiter.sv
// ==== aqp_ebus_arbiter: arbitrates the Z80 external bus between ESP SPI (m0) and DMA (m1) ====
// ==== rev 1.0 ====
`default_nettype none

module aqp_ebus_arbiter
   import aqp_ebus_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ebus_phi,
   input  logic                m0_busreq_n,
   input  logic [EBUS_A_W-1:0] m0_a,
   input  logic [EBUS_D_W-1:0] m0_wrdata,
   input  logic                m0_wrdata_en,
   input  logic                m0_rd_n,
   input  logic                m0_wr_n,
   input  logic                m0_mreq_n,
   input  logic                m0_iorq_n,
   output logic                m0_grant,
   input  logic                m1_busreq_n,
   input  logic [EBUS_A_W-1:0] m1_a,
   input  logic [EBUS_D_W-1:0] m1_wrdata,
   input  logic                m1_wrdata_en,
   input  logic                m1_rd_n,
   input  logic                m1_wr_n,
   input  logic                m1_mreq_n,
   input  logic                m1_iorq_n,
   output logic                m1_grant,
   input  logic                ebus_busack_n,
   output logic                ebus_busreq_n,
   output logic [EBUS_A_W-1:0] ebus_a,
   output logic [EBUS_D_W-1:0] ebus_wrdata,
   output logic                ebus_wrdata_en,
   output logic                ebus_rd_n,
   output logic                ebus_wr_n,
   output logic                ebus_mreq_n,
   output logic                ebus_iorq_n
);

   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

   arb_state_e        state_q, state_d;
   logic              target_q, target_d;
   logic              ptr_q, ptr_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              phi_q;

   logic              busack_sync_n, acked, phi_rise, phi_fall;
   logic              owner, owner_req, other_req, owner_quiet;
   logic [HOLD_W-1:0] hold_inc;
   ebus_bundle_t      m0_bus, m1_bus, own_bus, out_bus;

   aqp_sync2 #(.RESET_VAL(1'b1)) u_busack_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (ebus_busack_n),
      .q_o   (busack_sync_n)
   );

   assign acked    = ~busack_sync_n;
   assign phi_rise =  ebus_phi & ~phi_q;
   assign phi_fall = ~ebus_phi &  phi_q;

   assign m0_bus = {m0_a, m0_wrdata, m0_wrdata_en, m0_rd_n, m0_wr_n, m0_mreq_n, m0_iorq_n};
   assign m1_bus = {m1_a, m1_wrdata, m1_wrdata_en, m1_rd_n, m1_wr_n, m1_mreq_n, m1_iorq_n};

   assign owner       = (state_q == ST_OWN1);
   assign own_bus     = owner ? m1_bus : m0_bus;
   assign owner_req   = owner ? ~m1_busreq_n : ~m0_busreq_n;
   assign other_req   = owner ? ~m0_busreq_n : ~m1_busreq_n;
   assign owner_quiet = is_quiet(own_bus);
   // Saturate so a long-waiting peer can never wrap the count back below the limit.
   assign hold_inc    = (hold_q == {HOLD_W{1'b1}}) ? hold_q : hold_q + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         target_q <= 1'b0;
         ptr_q    <= 1'b0;
         hold_q   <= '0;
         phi_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         ptr_q    <= ptr_d;
         hold_q   <= hold_d;
         phi_q    <= ebus_phi;
      end
   end

   always_comb begin
      state_d       = state_q;
      target_d      = target_q;
      ptr_d         = ptr_q;
      hold_d        = hold_q;
      m0_grant      = 1'b0;
      m1_grant      = 1'b0;
      ebus_busreq_n = 1'b1;
      out_bus       = EBUS_IDLE;
      case (state_q)
         ST_IDLE: begin
            if (!m0_busreq_n || !m1_busreq_n) begin
               state_d  = ST_REQ;
               target_d = (!m0_busreq_n && !m1_busreq_n) ? ptr_q : ~m1_busreq_n;
            end
         end
         ST_REQ: begin
            ebus_busreq_n = 1'b0;
            if (acked && phi_rise) begin
               state_d = target_q ? ST_OWN1 : ST_OWN0;
               hold_d  = '0;
            end
         end
         ST_OWN0, ST_OWN1: begin
            ebus_busreq_n = 1'b0;
            m0_grant      = ~owner;
            m1_grant      = owner;
            out_bus       = own_bus;
            if (phi_fall) begin
               if (other_req) begin
                  hold_d = hold_inc;
               end
               // Ownership only moves on a quiet cycle, whether released or preempted.
               if (owner_quiet && (!owner_req || (other_req && hold_inc >= HOLD_LIMIT))) begin
                  state_d  = other_req ? ST_HANDOFF : ST_REL;
                  target_d = other_req ? ~owner : owner;
               end
            end
         end
         ST_HANDOFF: begin
            ebus_busreq_n = 1'b0;
            if (phi_fall) begin
               state_d = target_q ? ST_OWN1 : ST_OWN0;
               hold_d  = '0;
               ptr_d   = ~ptr_q;
            end
         end
         ST_REL: begin
            if (!acked) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ebus_a         = out_bus.a;
   assign ebus_wrdata    = out_bus.wrdata;
   assign ebus_wrdata_en = out_bus.wrdata_en;
   assign ebus_rd_n      = out_bus.rd_n;
   assign ebus_wr_n      = out_bus.wr_n;
   assign ebus_mreq_n    = out_bus.mreq_n;
   assign ebus_iorq_n    = out_bus.iorq_n;

endmodule

`default_nettype wire

// File: tb/tb_aqp_ebus_arbiter.sv
// ==== tb_aqp_ebus_arbiter: scoreboard bench for the ebus arbiter with a simple Z80 BUSACK model ====
// ==== rev 1.0 ====
`default_nettype none

module tb_aqp_ebus_arbiter;

   localparam int unsigned MAX_HOLD = 4;

   typedef struct packed {
      logic        owner;
      logic [15:0] a;
   } grant_t;

   logic        clk = 1'b0, reset = 1'b1, ebus_phi = 1'b0, ebus_busack_n = 1'b1;
   logic        m0_busreq_n = 1'b1, m1_busreq_n = 1'b1;
   logic [15:0] m0_a = '0, m1_a = '0;
   logic [7:0]  m0_wrdata = '0, m1_wrdata = '0;
   logic        m0_wrdata_en = 1'b0, m0_rd_n = 1'b1, m0_wr_n = 1'b1, m0_mreq_n = 1'b1, m0_iorq_n = 1'b1;
   logic        m1_wrdata_en = 1'b0, m1_rd_n = 1'b1, m1_wr_n = 1'b1, m1_mreq_n = 1'b1, m1_iorq_n = 1'b1;
   logic        m0_grant, m1_grant, ebus_busreq_n;
   logic [15:0] ebus_a;
   logic [7:0]  ebus_wrdata;
   logic        ebus_wrdata_en, ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n;

   int          n_pass = 0, n_total = 0, phi_falls = 0;
   logic        both_seen = 1'b0;
   grant_t      exp_q[$];

   aqp_ebus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .reset(reset), .ebus_phi(ebus_phi),
      .m0_busreq_n(m0_busreq_n), .m0_a(m0_a), .m0_wrdata(m0_wrdata), .m0_wrdata_en(m0_wrdata_en),
      .m0_rd_n(m0_rd_n), .m0_wr_n(m0_wr_n), .m0_mreq_n(m0_mreq_n), .m0_iorq_n(m0_iorq_n), .m0_grant(m0_grant),
      .m1_busreq_n(m1_busreq_n), .m1_a(m1_a), .m1_wrdata(m1_wrdata), .m1_wrdata_en(m1_wrdata_en),
      .m1_rd_n(m1_rd_n), .m1_wr_n(m1_wr_n), .m1_mreq_n(m1_mreq_n), .m1_iorq_n(m1_iorq_n), .m1_grant(m1_grant),
      .ebus_busack_n(ebus_busack_n), .ebus_busreq_n(ebus_busreq_n), .ebus_a(ebus_a),
      .ebus_wrdata(ebus_wrdata), .ebus_wrdata_en(ebus_wrdata_en), .ebus_rd_n(ebus_rd_n),
      .ebus_wr_n(ebus_wr_n), .ebus_mreq_n(ebus_mreq_n), .ebus_iorq_n(ebus_iorq_n)
   );

   always #5 clk = ~clk;

   // phi period is eight clk cycles
   initial forever begin
      repeat (4) @(posedge clk);
      #1 ebus_phi = ~ebus_phi;
   end

   // Z80: BUSACK_n falls on the third phi rise with BUSREQ_n low, rises on the first rise after release
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge ebus_phi);
         if (ebus_busreq_n == 1'b0) begin
            if (cnt < 3) cnt++;
            if (cnt >= 3) ebus_busack_n = 1'b0;
         end else begin
            cnt = 0;
            ebus_busack_n = 1'b1;
         end
      end
   end

   initial forever begin
      @(negedge ebus_phi);
      phi_falls++;
   end

   initial forever begin
      @(negedge clk);
      if (m0_grant === 1'b1 && m1_grant === 1'b1) both_seen = 1'b1;
   end

   task automatic wait_grant(output logic ok, output logic who);
      ok = 1'b0; who = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (m0_grant === 1'b1 || m1_grant === 1'b1) begin ok = 1'b1; who = m1_grant; break; end
      end
   endtask

   task automatic wait_nogrant(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (m0_grant === 1'b0 && m1_grant === 1'b0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic settle();
      for (int i = 0; i < 100 && ebus_busack_n !== 1'b1; i++) @(negedge clk);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      m1_a = 16'hFFFF; m1_mreq_n = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_total++; if (m0_grant !== 1'b0) $display("FAIL reset_m0_grant: got %b want 0", m0_grant); else n_pass++;
      n_total++; if (m1_grant !== 1'b0) $display("FAIL reset_m1_grant: got %b want 0", m1_grant); else n_pass++;
      n_total++; if (ebus_busreq_n !== 1'b1) $display("FAIL reset_busreq: got %b want 1", ebus_busreq_n); else n_pass++;
      n_total++; if (ebus_mreq_n !== 1'b1) $display("FAIL reset_mreq: got %b want 1", ebus_mreq_n); else n_pass++;
      n_total++; if (ebus_a !== 16'h0) $display("FAIL reset_addr: got %h want 0000", ebus_a); else n_pass++;
      reset = 1'b0;
      m1_a = 16'h0; m1_mreq_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_m0();
      logic ok, who;
      grant_t e;
      m0_a = 16'h3800; m0_mreq_n = 1'b0; m0_rd_n = 1'b0; m0_busreq_n = 1'b0;
      exp_q.push_back('{1'b0, 16'h3800});
      wait_grant(ok, who);
      e = exp_q.pop_front();
      n_total++; if (!ok) $display("FAIL single_grant: got timeout want grant"); else n_pass++;
      n_total++; if (who !== e.owner) $display("FAIL single_owner: got m%0d want m%0d", who, e.owner); else n_pass++;
      n_total++; if (ebus_a !== e.a) $display("FAIL single_addr: got %h want %h", ebus_a, e.a); else n_pass++;
      n_total++; if (ebus_phi !== 1'b1 || ebus_busack_n !== 1'b0)
         $display("FAIL single_on_rise: got phi=%b busack_n=%b want 1/0", ebus_phi, ebus_busack_n); else n_pass++;
      m1_a = 16'hBEEF; m1_wr_n = 1'b0;
      @(negedge clk);
      n_total++; if (ebus_a !== 16'h3800 || ebus_wr_n !== 1'b1 || ebus_rd_n !== 1'b0)
         $display("FAIL single_nonowner_ignored: got a=%h wr_n=%b rd_n=%b want 3800/1/0", ebus_a, ebus_wr_n, ebus_rd_n); else n_pass++;
      m1_a = 16'h0; m1_wr_n = 1'b1;
      m0_mreq_n = 1'b1; m0_rd_n = 1'b1; m0_busreq_n = 1'b1;
      wait_nogrant(ok);
      n_total++; if (!ok || ebus_busreq_n !== 1'b1)
         $display("FAIL single_release: got ok=%b busreq_n=%b want 1/1", ok, ebus_busreq_n); else n_pass++;
      settle();
   endtask

   task automatic test_both_handoff();
      logic ok, who;
      int   gap;
      grant_t e;
      m0_a = 16'h1111; m1_a = 16'h2222; m1_mreq_n = 1'b0; m1_rd_n = 1'b0;
      m0_busreq_n = 1'b0; m1_busreq_n = 1'b0;
      exp_q.push_back('{1'b0, 16'h1111});
      exp_q.push_back('{1'b1, 16'h2222});
      wait_grant(ok, who);
      e = exp_q.pop_front();
      n_total++; if (!ok || who !== e.owner || ebus_a !== e.a)
         $display("FAIL both_first: got ok=%b m%0d a=%h want m%0d a=%h", ok, who, ebus_a, e.owner, e.a); else n_pass++;
      repeat (3) @(negedge clk);
      m0_busreq_n = 1'b1;
      wait_nogrant(ok);
      n_total++; if (!ok || ebus_busreq_n !== 1'b0 || ebus_rd_n !== 1'b1 || ebus_a !== 16'h0)
         $display("FAIL both_handoff_bus: got busreq_n=%b rd_n=%b a=%h want 0/1/0000", ebus_busreq_n, ebus_rd_n, ebus_a); else n_pass++;
      gap = 0;
      for (int i = 0; i < 100 && m0_grant !== 1'b1 && m1_grant !== 1'b1; i++) begin
         gap++;
         @(negedge clk);
      end
      n_total++; if (gap != 8) $display("FAIL both_handoff_len: got %0d want 8 clk", gap); else n_pass++;
      e = exp_q.pop_front();
      n_total++; if (m1_grant !== e.owner || ebus_a !== e.a || ebus_mreq_n !== 1'b0)
         $display("FAIL both_second: got m1_grant=%b a=%h mreq_n=%b want %b/%h/0", m1_grant, ebus_a, ebus_mreq_n, e.owner, e.a); else n_pass++;
      m1_mreq_n = 1'b1; m1_rd_n = 1'b1; m1_busreq_n = 1'b1;
      wait_nogrant(ok);
      n_total++; if (!ok || ebus_busreq_n !== 1'b1) $display("FAIL both_release: got busreq_n=%b want 1", ebus_busreq_n); else n_pass++;
      settle();
   endtask

   task automatic test_max_hold();
      logic ok, who, held;
      int   f0;
      grant_t e;
      m0_a = 16'h4444; m1_a = 16'h5555; m0_mreq_n = 1'b0;
      m0_busreq_n = 1'b0; m1_busreq_n = 1'b0;
      exp_q.push_back('{1'b1, 16'h5555});
      exp_q.push_back('{1'b0, 16'h4444});
      exp_q.push_back('{1'b1, 16'h5555});
      wait_grant(ok, who);
      e = exp_q.pop_front();
      n_total++; if (!ok || who !== e.owner || ebus_a !== e.a)
         $display("FAIL rr_first: got ok=%b m%0d a=%h want m%0d a=%h", ok, who, ebus_a, e.owner, e.a); else n_pass++;
      f0 = phi_falls;
      wait_nogrant(ok);
      n_total++; if (!ok || phi_falls - f0 != 4) $display("FAIL hold_quiet_falls: got %0d want 4", phi_falls - f0); else n_pass++;
      wait_grant(ok, who);
      e = exp_q.pop_front();
      n_total++; if (!ok || who !== e.owner || ebus_a !== e.a || ebus_mreq_n !== 1'b0)
         $display("FAIL hold_to_m0: got m%0d a=%h mreq_n=%b want m%0d a=%h", who, ebus_a, ebus_mreq_n, e.owner, e.a); else n_pass++;
      f0 = phi_falls; held = 1'b1;
      for (int i = 0; i < 200 && (phi_falls - f0) < 8; i++) begin
         @(negedge clk);
         if (m0_grant !== 1'b1) held = 1'b0;
      end
      n_total++; if (held !== 1'b1) $display("FAIL hold_no_preempt: got preempted want held"); else n_pass++;
      @(posedge ebus_phi);
      @(negedge clk);
      m0_mreq_n = 1'b1;
      f0 = phi_falls;
      wait_nogrant(ok);
      n_total++; if (!ok || phi_falls - f0 != 1) $display("FAIL hold_after_quiet: got %0d falls want 1", phi_falls - f0); else n_pass++;
      wait_grant(ok, who);
      e = exp_q.pop_front();
      n_total++; if (!ok || who !== e.owner || ebus_a !== e.a)
         $display("FAIL hold_back_m1: got m%0d a=%h want m%0d a=%h", who, ebus_a, e.owner, e.a); else n_pass++;
      m0_busreq_n = 1'b1; m1_busreq_n = 1'b1;
      wait_nogrant(ok);
      settle();
   endtask

   task automatic test_drop_nonquiet();
      logic ok, who, held, early;
      int   f0;
      grant_t e;
      m1_a = 16'h6666; m1_wrdata = 8'hA5; m1_busreq_n = 1'b0;
      exp_q.push_back('{1'b1, 16'h6666});
      wait_grant(ok, who);
      e = exp_q.pop_front();
      n_total++; if (!ok || who !== e.owner || ebus_a !== e.a)
         $display("FAIL drop_grant: got m%0d a=%h want m%0d a=%h", who, ebus_a, e.owner, e.a); else n_pass++;
      m1_wr_n = 1'b0; m1_wrdata_en = 1'b1; m1_mreq_n = 1'b0; m1_busreq_n = 1'b1;
      f0 = phi_falls; held = 1'b1;
      for (int i = 0; i < 200 && (phi_falls - f0) < 3; i++) begin
         @(negedge clk);
         if (m1_grant !== 1'b1) held = 1'b0;
      end
      n_total++; if (held !== 1'b1 || ebus_wr_n !== 1'b0 || ebus_wrdata !== 8'hA5 || ebus_wrdata_en !== 1'b1)
         $display("FAIL drop_held: got held=%b wr_n=%b d=%h en=%b want 1/0/a5/1", held, ebus_wr_n, ebus_wrdata, ebus_wrdata_en); else n_pass++;
      m1_wr_n = 1'b1; m1_wrdata_en = 1'b0; m1_mreq_n = 1'b1;
      wait_nogrant(ok);
      n_total++; if (!ok || ebus_busreq_n !== 1'b1) $display("FAIL drop_rel: got busreq_n=%b want 1", ebus_busreq_n); else n_pass++;
      m0_a = 16'h7777; m0_busreq_n = 1'b0;
      exp_q.push_back('{1'b0, 16'h7777});
      early = 1'b0;
      for (int i = 0; i < 100 && ebus_busack_n !== 1'b1; i++) begin
         @(negedge clk);
         if (ebus_busreq_n !== 1'b1) early = 1'b1;
      end
      n_total++; if (early !== 1'b0) $display("FAIL rel_waits_idle: got busreq_n low before busack_n high"); else n_pass++;
      wait_grant(ok, who);
      e = exp_q.pop_front();
      n_total++; if (!ok || who !== e.owner || ebus_a !== e.a)
         $display("FAIL rel_then_m0: got m%0d a=%h want m%0d a=%h", who, ebus_a, e.owner, e.a); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic ok, who;
      grant_t e;
      m0_mreq_n = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_total++; if (ebus_mreq_n !== 1'b1 || ebus_busreq_n !== 1'b1 || m0_grant !== 1'b0 || m1_grant !== 1'b0)
         $display("FAIL async_reset: got mreq_n=%b busreq_n=%b g0=%b g1=%b want 1/1/0/0",
                  ebus_mreq_n, ebus_busreq_n, m0_grant, m1_grant); else n_pass++;
      @(negedge clk);
      m0_mreq_n = 1'b1; m0_busreq_n = 1'b1;
      reset = 1'b0;
      repeat (10) @(negedge clk);
      n_total++; if (ebus_busreq_n !== 1'b1 || m0_grant !== 1'b0)
         $display("FAIL reset_idle: got busreq_n=%b g0=%b want 1/0", ebus_busreq_n, m0_grant); else n_pass++;
      settle();
      m0_a = 16'h0123; m0_busreq_n = 1'b0;
      exp_q.push_back('{1'b0, 16'h0123});
      wait_grant(ok, who);
      e = exp_q.pop_front();
      n_total++; if (!ok || who !== e.owner || ebus_a !== e.a)
         $display("FAIL reset_regrant: got m%0d a=%h want m%0d a=%h", who, ebus_a, e.owner, e.a); else n_pass++;
      m0_busreq_n = 1'b1;
      wait_nogrant(ok);
   endtask

   task automatic test_exclusion();
      n_total++; if (both_seen !== 1'b0) $display("FAIL grant_exclusive: got both grants high want at most one"); else n_pass++;
      n_total++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_m0();
      test_both_handoff();
      test_max_hold();
      test_drop_nonquiet();
      test_reset_mid();
      test_exclusion();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
